// File: rtl/jpeg_stream_sequencer_pkg.sv
// Shared types and constants for the JPEG Y/Cb/Cr stream sequencer.
package jpeg_stream_sequencer_pkg;

  localparam int unsigned WORD_W             = 32;
  localparam int unsigned ENTRY_W            = WORD_W + 1;
  localparam int unsigned NUM_CHAN           = 3;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    SERVE_Y  = 2'd0,
    SERVE_CB = 2'd1,
    SERVE_CR = 2'd2
  } state_t;

  localparam logic [1:0] CHAN_Y  = 2'd0;
  localparam logic [1:0] CHAN_CB = 2'd1;
  localparam logic [1:0] CHAN_CR = 2'd2;

  // One buffered word together with its end-of-block marker.
  typedef struct packed {
    logic              eob;
    logic [WORD_W-1:0] word;
  } entry_t;

  function automatic state_t next_state(input state_t s);
    case (s)
      SERVE_Y:  return SERVE_CB;
      SERVE_CB: return SERVE_CR;
      default:  return SERVE_Y;
    endcase
  endfunction

endpackage

// File: rtl/jpeg_stream_sequencer_chan_fifo.sv
// Per-channel show-ahead FIFO; a push into a full FIFO is taken only if a pop frees a slot.
module chan_fifo
  import jpeg_stream_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] dout,
  output logic               empty,
  output logic               full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_q, wr_d;
  logic [AW-1:0]      rd_q, rd_d;
  logic [CW-1:0]      count_q, count_d;
  logic               do_push;
  logic               do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CW'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = do_push ? ptr_inc(wr_q) : wr_q;
    rd_d    = do_pop ? ptr_inc(rd_q) : rd_q;
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem_q[wr_q] <= din;
    end
  end

  assign dout = mem_q[rd_q];

endmodule

// File: rtl/jpeg_stream_sequencer.sv
// Merges the Y, Cb and Cr encoded streams into one stream, a whole 8x8 block per channel in turn.
module jpeg_stream_sequencer
  import jpeg_stream_sequencer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] y_JPEG_bitstream,
  input  logic        y_data_ready,
  input  logic        y_eob,
  input  logic [31:0] cb_JPEG_bitstream,
  input  logic        cb_data_ready,
  input  logic        cb_eob,
  input  logic [31:0] cr_JPEG_bitstream,
  input  logic        cr_data_ready,
  input  logic        cr_eob,
  input  logic        out_ready,
  output logic [31:0] out_bitstream,
  output logic        out_valid,
  output logic [1:0]  out_chan,
  output logic        out_last,
  output logic        mcu_done,
  output logic [2:0]  overflow
);

  entry_t               din [NUM_CHAN];
  logic [ENTRY_W-1:0]   dout_raw [NUM_CHAN];
  logic [NUM_CHAN-1:0]  push, pop, empty, full, sel;
  entry_t               head;
  logic                 head_avail;
  logic                 load;
  logic [NUM_CHAN-1:0]  overflow_d;

  state_t               state_q;
  logic [WORD_W-1:0]    out_word_q;
  logic [1:0]           out_chan_q;
  logic                 out_last_q;
  logic                 out_valid_q;
  logic                 mcu_done_q;
  logic [NUM_CHAN-1:0]  overflow_q;

  always_comb begin
    push   = {cr_data_ready, cb_data_ready, y_data_ready};
    din[0] = '{eob: y_eob,  word: y_JPEG_bitstream};
    din[1] = '{eob: cb_eob, word: cb_JPEG_bitstream};
    din[2] = '{eob: cr_eob, word: cr_JPEG_bitstream};
  end

  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_fifo
    chan_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[c]),
      .pop   (pop[c]),
      .din   (din[c]),
      .dout  (dout_raw[c]),
      .empty (empty[c]),
      .full  (full[c])
    );
  end

  // Only the FIFO of the channel being served may feed the output register.
  always_comb begin
    head       = '0;
    head_avail = 1'b0;
    sel        = '0;
    case (state_q)
      SERVE_Y: begin
        head       = entry_t'(dout_raw[0]);
        head_avail = !empty[0];
        sel        = 3'b001;
      end
      SERVE_CB: begin
        head       = entry_t'(dout_raw[1]);
        head_avail = !empty[1];
        sel        = 3'b010;
      end
      SERVE_CR: begin
        head       = entry_t'(dout_raw[2]);
        head_avail = !empty[2];
        sel        = 3'b100;
      end
      default: ;
    endcase
    load       = head_avail && (!out_valid_q || out_ready);
    pop        = sel & {NUM_CHAN{load}};
    overflow_d = overflow_q | (push & full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SERVE_Y;
      out_word_q  <= '0;
      out_chan_q  <= CHAN_Y;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      mcu_done_q  <= 1'b0;
      overflow_q  <= '0;
    end else begin
      mcu_done_q <= out_valid_q && out_ready && (out_chan_q == CHAN_CR) && out_last_q;
      overflow_q <= overflow_d;
      if (load) begin
        out_word_q  <= head.word;
        out_chan_q  <= 2'(state_q);
        out_last_q  <= head.eob;
        out_valid_q <= 1'b1;
        if (head.eob) begin
          state_q <= next_state(state_q);
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_bitstream = out_word_q;
  assign out_valid     = out_valid_q;
  assign out_chan      = out_chan_q;
  assign out_last      = out_last_q;
  assign mcu_done      = mcu_done_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_jpeg_stream_sequencer.sv
// Self-checking bench: directed vector table, corner-case sequences and a random run against a queue model.
module tb_jpeg_stream_sequencer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] y_JPEG_bitstream, cb_JPEG_bitstream, cr_JPEG_bitstream;
  logic        y_data_ready, cb_data_ready, cr_data_ready;
  logic        y_eob, cb_eob, cr_eob;
  logic        out_ready;
  logic [31:0] out_bitstream;
  logic        out_valid;
  logic [1:0]  out_chan;
  logic        out_last;
  logic        mcu_done;
  logic [2:0]  overflow;

  always #5 clk = ~clk;

  jpeg_stream_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .y_JPEG_bitstream  (y_JPEG_bitstream),
    .y_data_ready      (y_data_ready),
    .y_eob             (y_eob),
    .cb_JPEG_bitstream (cb_JPEG_bitstream),
    .cb_data_ready     (cb_data_ready),
    .cb_eob            (cb_eob),
    .cr_JPEG_bitstream (cr_JPEG_bitstream),
    .cr_data_ready     (cr_data_ready),
    .cr_eob            (cr_eob),
    .out_ready         (out_ready),
    .out_bitstream     (out_bitstream),
    .out_valid         (out_valid),
    .out_chan          (out_chan),
    .out_last          (out_last),
    .mcu_done          (mcu_done),
    .overflow          (overflow)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: per-channel queues, a round-robin pointer and one output slot.
  logic [32:0] mq [3][$];
  int          m_state;
  logic        m_valid;
  logic [31:0] m_word;
  logic [1:0]  m_chan;
  logic        m_last;
  logic        m_mcu;
  logic [2:0]  m_ovf;

  int          run_len, max_run, mcu_count, target_hits, hs_total;
  logic [31:0] target;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic        free, load;
    logic [32:0] hd;
    logic [2:0]  dr;
    logic [32:0] ent [3];
    dr     = {cr_data_ready, cb_data_ready, y_data_ready};
    ent[0] = {y_eob, y_JPEG_bitstream};
    ent[1] = {cb_eob, cb_JPEG_bitstream};
    ent[2] = {cr_eob, cr_JPEG_bitstream};
    if (rst) begin
      for (int c = 0; c < 3; c++) mq[c].delete();
      m_state = 0; m_valid = 0; m_word = 0; m_chan = 0; m_last = 0; m_mcu = 0; m_ovf = 0;
      return;
    end
    m_mcu = m_valid && out_ready && (m_chan == 2'd2) && m_last;
    free  = !m_valid || out_ready;
    load  = free && (mq[m_state].size() > 0);
    if (load) begin
      hd      = mq[m_state].pop_front();
      m_word  = hd[31:0];
      m_last  = hd[32];
      m_chan  = 2'(m_state);
      m_valid = 1'b1;
      if (hd[32]) m_state = (m_state + 1) % 3;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    for (int c = 0; c < 3; c++) begin
      if (dr[c]) begin
        if (mq[c].size() < DEPTH) mq[c].push_back(ent[c]);
        else m_ovf[c] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      hs_total++;
      if (out_bitstream == target) target_hits++;
    end else begin
      run_len = 0;
    end
    @(posedge clk);
    model_step();
    #1;
    chk("model_out_valid", 32'(out_valid), 32'(m_valid));
    chk("model_out_bitstream", out_bitstream, m_word);
    chk("model_out_chan", 32'(out_chan), 32'(m_chan));
    chk("model_out_last", 32'(out_last), 32'(m_last));
    chk("model_mcu_done", 32'(mcu_done), 32'(m_mcu));
    chk("model_overflow", 32'(overflow), 32'(m_ovf));
    if (mcu_done === 1'b1) mcu_count++;
    @(negedge clk);
  endtask

  task automatic idle_in();
    y_data_ready = 0; cb_data_ready = 0; cr_data_ready = 0;
    y_eob = 0; cb_eob = 0; cr_eob = 0;
    y_JPEG_bitstream = 0; cb_JPEG_bitstream = 0; cr_JPEG_bitstream = 0;
  endtask

  task automatic drive(input int c, input logic [31:0] w, input logic e);
    idle_in();
    case (c)
      0: begin y_data_ready = 1; y_JPEG_bitstream = w; y_eob = e; end
      1: begin cb_data_ready = 1; cb_JPEG_bitstream = w; cb_eob = e; end
      default: begin cr_data_ready = 1; cr_JPEG_bitstream = w; cr_eob = e; end
    endcase
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic clear_stats();
    run_len = 0; max_run = 0; mcu_count = 0; target_hits = 0; hs_total = 0;
  endtask

  typedef struct {
    logic        rst;
    logic [2:0]  dr;
    logic [2:0]  eob;
    logic [31:0] w;
    logic        ready;
    logic        e_valid;
    logic [31:0] e_word;
    logic [1:0]  e_chan;
    logic        e_last;
    logic        e_mcu;
  } vec_t;

  vec_t tbl [12];

  initial begin
    // Ordering: Cr block, then Cb, then Y pushed; output must come out Y, Cb, Cr.
    tbl[0]  = '{1'b1, 3'b000, 3'b000, 32'h00, 1'b1, 1'b0, 32'h00, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 3'b100, 3'b000, 32'hC0, 1'b1, 1'b0, 32'h00, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 3'b100, 3'b100, 32'hC1, 1'b1, 1'b0, 32'h00, 2'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 3'b010, 3'b010, 32'hB0, 1'b1, 1'b0, 32'h00, 2'd0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 3'b001, 3'b000, 32'hA0, 1'b1, 1'b0, 32'h00, 2'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 3'b001, 3'b001, 32'hA1, 1'b1, 1'b1, 32'hA0, 2'd0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 3'b000, 3'b000, 32'h00, 1'b1, 1'b1, 32'hA1, 2'd0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 3'b000, 3'b000, 32'h00, 1'b1, 1'b1, 32'hB0, 2'd1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 3'b000, 3'b000, 32'h00, 1'b1, 1'b1, 32'hC0, 2'd2, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 3'b000, 3'b000, 32'h00, 1'b1, 1'b1, 32'hC1, 2'd2, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 3'b000, 3'b000, 32'h00, 1'b1, 1'b0, 32'h00, 2'd0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 3'b000, 3'b000, 32'h00, 1'b1, 1'b0, 32'h00, 2'd0, 1'b0, 1'b0};

    target = 32'hFFFF_FFFF;
    clear_stats();
    idle_in();
    out_ready = 1'b1;
    rst = 1'b1;
    tick();
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_bitstream", out_bitstream, 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst;
      y_data_ready = tbl[i].dr[0]; cb_data_ready = tbl[i].dr[1]; cr_data_ready = tbl[i].dr[2];
      y_eob = tbl[i].eob[0]; cb_eob = tbl[i].eob[1]; cr_eob = tbl[i].eob[2];
      y_JPEG_bitstream = tbl[i].w; cb_JPEG_bitstream = tbl[i].w; cr_JPEG_bitstream = tbl[i].w;
      out_ready = tbl[i].ready;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d_mcu", i), 32'(mcu_done), 32'(tbl[i].e_mcu));
      if (tbl[i].e_valid) begin
        chk($sformatf("vec%0d_word", i), out_bitstream, tbl[i].e_word);
        chk($sformatf("vec%0d_chan", i), 32'(out_chan), 32'(tbl[i].e_chan));
        chk($sformatf("vec%0d_last", i), 32'(out_last), 32'(tbl[i].e_last));
      end
    end
    rst = 1'b0;

    // Backpressure: a held word stays put and is accepted exactly once.
    do_reset();
    out_ready = 1'b0;
    drive(0, 32'h1234_5678, 1'b1);
    tick();
    idle_in();
    tick();
    clear_stats();
    target = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_word", out_bitstream, 32'h1234_5678);
      chk("bp_chan", 32'(out_chan), 32'd0);
      chk("bp_last", 32'(out_last), 32'd1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("bp_accept_count", 32'(target_hits), 32'd1);
    chk("bp_valid_after", 32'(out_valid), 32'd0);

    // Overflow: Cb is not served while Y is, so only DEPTH words fit.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'hB00 + 32'(i), (i == 3));
      tick();
    end
    idle_in();
    chk("ovf_flags", 32'(overflow), 32'b010);
    out_ready = 1'b1;
    drive(0, 32'h77, 1'b1);
    tick();
    idle_in();
    clear_stats();
    for (int i = 0; i < 8; i++) tick();
    chk("ovf_drained_words", 32'(hs_total), 32'd5);
    chk("ovf_sticky", 32'(overflow), 32'b010);

    // Push into a full Y FIFO in the same cycle as a pop: accepted, no overflow.
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(0, 32'(i), 1'b0);
      tick();
    end
    out_ready = 1'b1;
    drive(0, 32'hDEAD, 1'b1);
    clear_stats();
    target = 32'hDEAD;
    tick();
    idle_in();
    chk("pp_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("pp_dead_seen", 32'(target_hits), 32'd1);
    chk("pp_overflow_end", 32'(overflow), 32'd0);

    // Reset in the middle of a Y block, with a word presented during reset.
    do_reset();
    out_ready = 1'b1;
    drive(0, 32'h100, 1'b0); tick();
    drive(0, 32'h101, 1'b0); tick();
    idle_in(); tick();
    drive(0, 32'h1FF, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_valid", 32'(out_valid), 32'd0);
    drive(0, 32'h200, 1'b0); tick();
    drive(0, 32'h201, 1'b1); tick();
    chk("mr_first_word", out_bitstream, 32'h200);
    chk("mr_first_chan", 32'(out_chan), 32'd0);
    chk("mr_first_valid", 32'(out_valid), 32'd1);
    idle_in(); tick();
    chk("mr_second_word", out_bitstream, 32'h201);
    tick();

    // Throughput: 3 MCUs of 8-word blocks streamed back to back.
    do_reset();
    out_ready = 1'b1;
    clear_stats();
    for (int b = 0; b < 3; b++)
      for (int c = 0; c < 3; c++)
        for (int i = 0; i < 8; i++) begin
          drive(c, {8'(b), 8'(c), 16'(i)}, (i == 7));
          tick();
        end
    idle_in();
    for (int i = 0; i < 5; i++) tick();
    chk("tp_consecutive", 32'(max_run), 32'd72);
    chk("tp_mcu_pulses", 32'(mcu_count), 32'd3);
    chk("tp_total", 32'(hs_total), 32'd72);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      y_data_ready  = ($urandom_range(0, 9) < 3);
      cb_data_ready = ($urandom_range(0, 9) < 3);
      cr_data_ready = ($urandom_range(0, 9) < 3);
      y_eob  = ($urandom_range(0, 3) == 0);
      cb_eob = ($urandom_range(0, 3) == 0);
      cr_eob = ($urandom_range(0, 3) == 0);
      y_JPEG_bitstream  = $urandom;
      cb_JPEG_bitstream = $urandom;
      cr_JPEG_bitstream = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    rst = 1'b0;
    idle_in();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
